// File: rtl/uart_rx.sv
// AXI4-Stream UART receiver: start bit, DATA_WIDTH data bits LSB-first, one stop bit.
// One bit lasts prescale*8 clk cycles; the start bit and every data bit are sampled at mid-bit.
module uart_rx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    input  logic                  rxd,
    output logic                  busy,
    output logic                  overrun_error,
    output logic                  frame_error,
    input  logic [9:0]            prescale
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    state_e                state_q, state_d;
    logic                  rxd_meta_q, rxd_meta_d;
    logic                  rxs_q, rxs_d;
    logic [12:0]           ptmr_q, ptmr_d;
    logic [3:0]            bcnt_q, bcnt_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  tvalid_q, tvalid_d;
    logic                  busy_q, busy_d;
    logic                  overrun_q, overrun_d;
    logic                  ferr_q, ferr_d;

    logic [12:0]           half_reload;
    logic [12:0]           bit_reload;

    // Start-bit wait is half a bit minus the cycles already spent in the synchroniser and IDLE.
    assign half_reload = {1'b0, prescale, 2'b00} - 13'd2;
    assign bit_reload  = {prescale, 3'b000} - 13'd1;

    assign rxd_meta_d = rxd;
    assign rxs_d      = rxd_meta_q;

    // NOTE: every variable written here gets a default first, so no path can leave it unassigned (no latch).
    always_comb begin
        state_d   = state_q;
        ptmr_d    = ptmr_q;
        bcnt_d    = bcnt_q;
        shreg_d   = shreg_q;
        tdata_d   = tdata_q;
        busy_d    = busy_q;
        overrun_d = 1'b0;
        ferr_d    = 1'b0;
        tvalid_d  = tvalid_q && !m_axis_tready;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (!rxs_q && (prescale != 10'd0)) begin
                    ptmr_d  = half_reload;
                    busy_d  = 1'b1;
                    state_d = START;
                end
            end

            START: begin
                if (ptmr_q != 13'd0) begin
                    ptmr_d = ptmr_q - 13'd1;
                end else if (rxs_q) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    ptmr_d  = bit_reload;
                    bcnt_d  = 4'(DATA_WIDTH);
                    state_d = DATA;
                end
            end

            DATA: begin
                if (ptmr_q != 13'd0) begin
                    ptmr_d = ptmr_q - 13'd1;
                end else begin
                    // Shifting in at the MSB leaves the first (LSB) wire bit at bit 0.
                    shreg_d = (shreg_q >> 1) | (DATA_WIDTH'(rxs_q) << (DATA_WIDTH - 1));
                    bcnt_d  = bcnt_q - 4'd1;
                    ptmr_d  = bit_reload;
                    if (bcnt_q == 4'd1) begin
                        state_d = STOP;
                    end
                end
            end

            STOP: begin
                if (ptmr_q != 13'd0) begin
                    ptmr_d = ptmr_q - 13'd1;
                end else begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                    if (rxs_q) begin
                        tdata_d   = shreg_q;
                        tvalid_d  = 1'b1;
                        overrun_d = tvalid_q && !m_axis_tready;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rxd_meta_q <= 1'b1;
            rxs_q      <= 1'b1;
            ptmr_q     <= '0;
            bcnt_q     <= '0;
            shreg_q    <= '0;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rxd_meta_q <= rxd_meta_d;
            rxs_q      <= rxs_d;
            ptmr_q     <= ptmr_d;
            bcnt_q     <= bcnt_d;
            shreg_q    <= shreg_d;
            tdata_q    <= tdata_d;
            tvalid_q   <= tvalid_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
            ferr_q     <= ferr_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign busy          = busy_q;
    assign overrun_error = overrun_q;
    assign frame_error   = ferr_q;

endmodule
